alu_add16_arbiter: RTL
======================

Name: alu_add16_arbiter

Overview:
- Shares one ALUAdd16 instance (16-bit unsigned add, overflow = carry out) between NREQ requesters.
- Fair round-robin arbitration, a valid/ready request handshake per requester, and a registered response held until the winner accepts it.
- Sits between the issue logic of multiple execution agents and the single shared adder datapath.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- PTRW, 2, width of the round-robin pointer; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i presents an operand pair.
- req_ready  out  NREQ  bit i: requester i's operands are captured this cycle.
- req_a  in  16*NREQ  operand A; requester i uses bits [16*i+15:16*i].
- req_b  in  16*NREQ  operand B, same packing as req_a.
- resp_valid  out  NREQ  one-hot; bit i means the result belongs to requester i.
- resp_ready  in  NREQ  bit i: requester i accepts the result.
- resp_out  out  16  registered sum, (a+b) mod 2^16.
- resp_overflow  out  1  registered carry out of the add.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock domain. Reset is synchronous and active-high; all registers update on the rising edge of clk.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, resp_valid = 0, resp_out = 0, resp_overflow = 0, busy = 0.
  - All operand and grant registers = 0.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate over req_valid. Search starts at index rr_ptr and wraps modulo NREQ; the first set bit wins (index g).
  - req_ready is combinational: it equals onehot(g) only while in IDLE with some req_valid set; otherwise all zeros.
  - Capture in the same cycle: op_a <= req_a[g], op_b <= req_b[g], grant <= g. Go to EXEC.
  - rr_ptr <= (g+1) mod NREQ at capture. rr_ptr does not change while no request is present.
  - No request: stay in IDLE.
- EXEC (exactly 1 cycle):
  - The adder sees op_a and op_b combinationally.
  - resp_out <= sum, resp_overflow <= carry, resp_valid <= onehot(grant). Go to RESP.
- RESP:
  - Hold resp_out, resp_overflow and resp_valid stable until resp_ready[grant] = 1.
  - resp_ready bits of non-granted requesters are ignored.
  - On acceptance: resp_valid <= 0 and go to IDLE. The next arbitration happens in the cycle after acceptance (no back-to-back bypass).
- Latency:
  - Capture cycle C; resp_valid is asserted in cycle C+2.
  - Minimum issue interval is 3 cycles per transaction when responses are accepted immediately.
- Requester obligations: req_valid and the operands must stay stable until req_ready. Dropping req_valid before grant is allowed and simply removes the request from arbitration.
- Arithmetic: unsigned only. Examples: 0xFFFF+0x0001 -> out 0x0000, overflow 1. 0x8000+0x8000 -> out 0x0000, overflow 1.
- Reset at any point (mid-EXEC or mid-RESP) discards the transaction: outputs return to reset values, no response is emitted, and rr_ptr = 0.
- Simultaneous requests: exactly one grant per arbitration. Starvation-free: any continuously valid requester is granted within NREQ arbitrations.
- A requester whose request is pending or in flight may assert req_valid again only after its response is accepted. Requests asserted earlier are not granted until the FSM returns to IDLE.

Optional Feature:
- Macro: ALU_ADD16_ARB_STATS_EN.
- Defined:
  - Adds output ports grant_count (16) and ovf_count (16), both reset to 0.
  - grant_count increments on every capture.
  - ovf_count increments on every EXEC cycle whose carry = 1.
  - Both counters saturate at 0xFFFF and do not wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: req_valid=0001, a=0x1234, b=0x0FCC -> req_ready=0001 in the same cycle; two cycles later resp_valid=0001, resp_out=0x2200, resp_overflow=0.
- Overflow: a=0xFFFF, b=0x0002 on requester 2 -> resp_out=0x0001, resp_overflow=1, resp_valid=0100.
- Fairness: all four valid continuously, responses accepted at once -> grant order 0,1,2,3,0,...; after grant 3, rr_ptr=0.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_out, resp_overflow and resp_valid stay constant, req_ready stays 0000, busy=1; releasing resp_ready returns the FSM to IDLE the next cycle.
- Reset in EXEC: assert rst one cycle after capture -> next cycle all outputs are 0 and no resp_valid ever appears for that transaction; the next grant starts from index 0.
- With ALU_ADD16_ARB_STATS_EN: 3 transactions, one overflowing -> grant_count=3, ovf_count=1. Force grant_count to 0xFFFF, then one more capture -> it remains 0xFFFF.

Source files
------------

// File: rtl/alu_add16_arbiter.sv
// rtl/alu_add16_arbiter.sv - round-robin arbiter sharing one 16-bit unsigned adder among NREQ requesters
// Define ALU_ADD16_ARB_STATS_EN to add saturating grant_count/ovf_count outputs.

module alu_add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b};
endmodule

module alu_add16_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      resp_valid,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [15:0]          resp_out,
    output logic                 resp_overflow,
    output logic                 busy
`ifdef ALU_ADD16_ARB_STATS_EN
    ,
    output logic [15:0]          grant_count,
    output logic [15:0]          ovf_count
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state, state_nxt;
    logic [PTRW-1:0] rr_ptr, grant, win, idx;
    logic            found;
    logic [15:0]     op_a, op_b, sum;
    logic            carry;
    logic            capture, exec, accept;

    alu_add16 u_add (
        .a     (op_a),
        .b     (op_b),
        .sum   (sum),
        .carry (carry)
    );

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTRW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        capture   = 1'b0;
        exec      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready = NREQ'(1) << win;
                    capture   = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                exec      = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready[grant]) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            grant         <= '0;
            op_a          <= '0;
            op_b          <= '0;
            resp_valid    <= '0;
            resp_out      <= '0;
            resp_overflow <= 1'b0;
        end else begin
            if (capture) begin
                op_a   <= req_a[16*win +: 16];
                op_b   <= req_b[16*win +: 16];
                grant  <= win;
                rr_ptr <= PTRW'((int'(win) + 1) % NREQ);
            end
            if (exec) begin
                resp_out      <= sum;
                resp_overflow <= carry;
                resp_valid    <= NREQ'(1) << grant;
            end
            if (accept) begin
                resp_valid <= '0;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef ALU_ADD16_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count <= '0;
            ovf_count   <= '0;
        end else begin
            if (capture && grant_count != 16'hFFFF) begin
                grant_count <= grant_count + 16'd1;
            end
            if (exec && carry && ovf_count != 16'hFFFF) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`endif

endmodule
